// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA overlay pipeline: coordinate and colour
// widths, the pixel/timing bundle carried between stages, and helpers for
// pulling one object's field out of a flat per-object bus.
// -----------------------------------------------------------------------------
package vga_pkg;

   localparam int HCOUNT_W = 12;
   localparam int RGB_W    = 12;

   // dx^2 + dy^2 with 12-bit dx/dy needs one bit more than a single square.
   localparam int D2_W     = 2*HCOUNT_W + 1;

   // Largest object count a flat bus is ever packed for.
   localparam int MAX_OBJ  = 8;

   // One pixel plus its timing, as it travels down the pipeline.
   typedef struct packed {
      logic [HCOUNT_W-1:0] hcount;
      logic [HCOUNT_W-1:0] vcount;
      logic                hsync;
      logic                vsync;
      logic                hblnk;
      logic                vblnk;
      logic [RGB_W-1:0]    rgb;
   } vga_pix_t;

   // Flat bus of 12-bit fields, sized for the largest object count.
   typedef logic [MAX_OBJ*HCOUNT_W-1:0] obj_bus12_t;

   // Field idx of a flat bus of 12-bit fields (object idx sits at [12*idx +: 12]).
   function automatic logic [HCOUNT_W-1:0] obj_field12(input obj_bus12_t  bus,
                                                       input int unsigned idx);
      return bus[idx*HCOUNT_W +: HCOUNT_W];
   endfunction

endpackage

// File: rtl/circle_dist.sv
// -----------------------------------------------------------------------------
// circle_dist
// Distance stages for one circle. Stage 1 registers |hcount-x| and
// |vcount-y| (computed from a 13-bit signed difference so off-screen centres
// never wrap) along with the radius; stage 2 registers the squared distance
// and the squared radius.
//
// Ports:
//   clk_in, rst              pixel clock, async active-low reset
//   hcount_in, vcount_in     current pixel coordinates
//   x_in, y_in               circle centre (shadow copy, stable per frame)
//   radius_in                circle radius
//   d2_out                   dx^2 + dy^2, two cycles after the pixel
//   r2_out                   radius^2, aligned with d2_out
// -----------------------------------------------------------------------------
module circle_dist
   import vga_pkg::*;
#(
   parameter int RADIUS_W = 7
) (
   input  logic                  clk_in,
   input  logic                  rst,
   input  logic [HCOUNT_W-1:0]   hcount_in,
   input  logic [HCOUNT_W-1:0]   vcount_in,
   input  logic [HCOUNT_W-1:0]   x_in,
   input  logic [HCOUNT_W-1:0]   y_in,
   input  logic [RADIUS_W-1:0]   radius_in,
   output logic [D2_W-1:0]       d2_out,
   output logic [2*RADIUS_W-1:0] r2_out
);

   localparam int R2_W = 2*RADIUS_W;

   // Stage 1: absolute differences. The extra sign bit keeps e.g. x=2000
   // against hcount=0 at a true distance of 2000 instead of wrapping.
   logic signed [HCOUNT_W:0] diff_x, diff_y;
   logic        [HCOUNT_W:0] neg_x, neg_y;
   logic [HCOUNT_W-1:0]      dx_next, dy_next;

   assign diff_x  = $signed({1'b0, hcount_in}) - $signed({1'b0, x_in});
   assign diff_y  = $signed({1'b0, vcount_in}) - $signed({1'b0, y_in});
   assign neg_x   = -diff_x;
   assign neg_y   = -diff_y;
   // |diff| <= 4095, so the magnitude always fits in 12 bits.
   assign dx_next = diff_x[HCOUNT_W] ? neg_x[HCOUNT_W-1:0] : diff_x[HCOUNT_W-1:0];
   assign dy_next = diff_y[HCOUNT_W] ? neg_y[HCOUNT_W-1:0] : diff_y[HCOUNT_W-1:0];

   logic [HCOUNT_W-1:0] dx_q, dy_q;
   logic [RADIUS_W-1:0] r_q;

   // NOTE: state is assigned with <= so every register samples the values
   // from before the edge; blocking '=' here would let later statements see
   // already-updated state and silently collapse pipeline stages.
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         dx_q <= '0;
         dy_q <= '0;
         r_q  <= '0;
      end else begin
         dx_q <= dx_next;
         dy_q <= dy_next;
         r_q  <= radius_in;
      end
   end

   // Stage 2: squares, widened before multiplying so nothing is truncated.
   logic [D2_W-1:0] dx_ext, dy_ext;
   logic [R2_W-1:0] r_ext;

   assign dx_ext = D2_W'(dx_q);
   assign dy_ext = D2_W'(dy_q);
   assign r_ext  = R2_W'(r_q);

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         d2_out <= '0;
         r2_out <= '0;
      end else begin
         d2_out <= dx_ext*dx_ext + dy_ext*dy_ext;
         r2_out <= r_ext*r_ext;
      end
   end

endmodule

// File: rtl/draw_circles_multi.sv
// -----------------------------------------------------------------------------
// draw_circles_multi
// Overlays NUM_OBJ filled circles on the pixel stream with fixed priority
// (object 0 wins). Object parameters are captured into shadow registers on
// the rising edge of vblnk_in so a frame is always drawn from one consistent
// set. Three-cycle latency on every pixel and timing path, one pixel/cycle.
// Also reports which objects won at least one active pixel last frame.
//
// Ports:
//   clk_in, rst                      pixel clock, async active-low reset
//   hcount_in, vcount_in             pixel coordinates
//   hsync/vsync/hblnk/vblnk_in       timing in
//   rgb_in                           upstream pixel
//   xpos_in, ypos_in                 centres, object i at [12i+11:12i]
//   radius_in                        radii, object i at [RADIUS_W*i +: RADIUS_W]
//   color_in                         colours, object i at [12i+11:12i]
//   obj_en_in                        per-object draw enable
//   hcount_out ... vblnk_out         timing delayed by 3 cycles
//   rgb_out                          composited pixel
//   obj_visible                      per-object "won a pixel" flags, last frame
//   frame_done                       one-cycle pulse when obj_visible updates
// -----------------------------------------------------------------------------
module draw_circles_multi
   import vga_pkg::*;
#(
   parameter int NUM_OBJ  = 4,
   parameter int RADIUS_W = 7
) (
   input  logic                          clk_in,
   input  logic                          rst,
   input  logic [HCOUNT_W-1:0]           hcount_in,
   input  logic [HCOUNT_W-1:0]           vcount_in,
   input  logic                          hsync_in,
   input  logic                          vsync_in,
   input  logic                          hblnk_in,
   input  logic                          vblnk_in,
   input  logic [RGB_W-1:0]              rgb_in,
   input  logic [NUM_OBJ*HCOUNT_W-1:0]   xpos_in,
   input  logic [NUM_OBJ*HCOUNT_W-1:0]   ypos_in,
   input  logic [NUM_OBJ*RADIUS_W-1:0]   radius_in,
   input  logic [NUM_OBJ*RGB_W-1:0]      color_in,
   input  logic [NUM_OBJ-1:0]            obj_en_in,
   output logic [HCOUNT_W-1:0]           hcount_out,
   output logic [HCOUNT_W-1:0]           vcount_out,
   output logic                          hsync_out,
   output logic                          vsync_out,
   output logic                          hblnk_out,
   output logic                          vblnk_out,
   output logic [RGB_W-1:0]              rgb_out,
   output logic [NUM_OBJ-1:0]            obj_visible,
   output logic                          frame_done
);

   localparam int R2_W  = 2*RADIUS_W;
   // Compare width covers both operands, whatever RADIUS_W is.
   localparam int CMP_W = (D2_W > R2_W) ? D2_W : R2_W;

   // ---------------------------------------------------------------------------
   // Pixel/timing pipeline
   // ---------------------------------------------------------------------------
   vga_pix_t pix_in, pix_s1, pix_s2, pix_next, pix_out;

   assign pix_in = '{hcount: hcount_in, vcount: vcount_in,
                     hsync:  hsync_in,  vsync:  vsync_in,
                     hblnk:  hblnk_in,  vblnk:  vblnk_in,
                     rgb:    rgb_in};

   // ---------------------------------------------------------------------------
   // Shadow registers, loaded once per frame on the vblnk_in rising edge.
   // pix_s1.vblnk is exactly last cycle's vblnk_in, so it doubles as the
   // edge detector's history bit.
   // ---------------------------------------------------------------------------
   logic [HCOUNT_W-1:0] x_sh     [NUM_OBJ];
   logic [HCOUNT_W-1:0] y_sh     [NUM_OBJ];
   logic [RADIUS_W-1:0] r_sh     [NUM_OBJ];
   logic [RGB_W-1:0]    color_sh [NUM_OBJ];
   logic [NUM_OBJ-1:0]  en_sh;
   logic                vblnk_rise_in;

   assign vblnk_rise_in = vblnk_in & ~pix_s1.vblnk;

   // NOTE: these arrays are a handful of flops, not a RAM, so they are
   // cleared by reset like any other state; a cleared enable is what makes
   // the first frame after reset a pure passthrough.
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         en_sh <= '0;
         for (int i = 0; i < NUM_OBJ; i++) begin
            x_sh[i]     <= '0;
            y_sh[i]     <= '0;
            r_sh[i]     <= '0;
            color_sh[i] <= '0;
         end
      end else if (vblnk_rise_in) begin
         en_sh <= obj_en_in;
         for (int i = 0; i < NUM_OBJ; i++) begin
            x_sh[i]     <= obj_field12(obj_bus12_t'(xpos_in), i);
            y_sh[i]     <= obj_field12(obj_bus12_t'(ypos_in), i);
            r_sh[i]     <= radius_in[i*RADIUS_W +: RADIUS_W];
            color_sh[i] <= obj_field12(obj_bus12_t'(color_in), i);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stages 1-2: timing, enables and colours ride alongside the distance
   // pipelines so stage 3 sees a self-consistent pixel even at the cycle
   // where the shadow set changes.
   // ---------------------------------------------------------------------------
   logic [NUM_OBJ-1:0] en_s1, en_s2;
   logic [RGB_W-1:0]   color_s1 [NUM_OBJ];
   logic [RGB_W-1:0]   color_s2 [NUM_OBJ];

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         pix_s1 <= '0;
         pix_s2 <= '0;
         en_s1  <= '0;
         en_s2  <= '0;
         for (int i = 0; i < NUM_OBJ; i++) begin
            color_s1[i] <= '0;
            color_s2[i] <= '0;
         end
      end else begin
         pix_s1 <= pix_in;
         pix_s2 <= pix_s1;
         en_s1  <= en_sh;
         en_s2  <= en_s1;
         for (int i = 0; i < NUM_OBJ; i++) begin
            color_s1[i] <= color_sh[i];
            color_s2[i] <= color_s1[i];
         end
      end
   end

   logic [D2_W-1:0] d2 [NUM_OBJ];
   logic [R2_W-1:0] r2 [NUM_OBJ];

   for (genvar g = 0; g < NUM_OBJ; g++) begin : g_dist
      circle_dist #(
         .RADIUS_W (RADIUS_W)
      ) u_circle_dist (
         .clk_in    (clk_in),
         .rst       (rst),
         .hcount_in (hcount_in),
         .vcount_in (vcount_in),
         .x_in      (x_sh[g]),
         .y_in      (y_sh[g]),
         .radius_in (r_sh[g]),
         .d2_out    (d2[g]),
         .r2_out    (r2[g])
      );
   end

   // ---------------------------------------------------------------------------
   // Stage 3: hit test, lowest-index priority mux, visibility accumulation.
   // ---------------------------------------------------------------------------
   logic [NUM_OBJ-1:0] hit, win, vis_acc;
   logic               found;
   logic               vblnk_rise_s3;

   // NOTE: every variable gets a default before the loops; a path that left
   // one unassigned would infer a latch instead of combinational logic.
   always_comb begin
      hit      = '0;
      win      = '0;
      found    = 1'b0;
      pix_next = pix_s2;
      for (int i = 0; i < NUM_OBJ; i++) begin
         hit[i] = en_s2[i] & (CMP_W'(d2[i]) <= CMP_W'(r2[i]))
                & ~pix_s2.hblnk & ~pix_s2.vblnk;
      end
      for (int i = 0; i < NUM_OBJ; i++) begin
         if (hit[i] && !found) begin
            found        = 1'b1;
            win[i]       = 1'b1;
            pix_next.rgb = color_s2[i];
         end
      end
   end

   // Rising edge of the delayed vblnk: stage-2 value high, output value low.
   // Both are cleared by reset, so a refill after reset cannot fake an edge
   // unless vblnk really goes from 0 to 1.
   assign vblnk_rise_s3 = pix_s2.vblnk & ~pix_out.vblnk;

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         pix_out     <= '0;
         vis_acc     <= '0;
         obj_visible <= '0;
         frame_done  <= 1'b0;
      end else begin
         pix_out    <= pix_next;
         frame_done <= vblnk_rise_s3;
         if (vblnk_rise_s3) begin
            // Include this cycle's winner so nothing is lost at the boundary.
            obj_visible <= vis_acc | win;
            vis_acc     <= '0;
         end else begin
            vis_acc     <= vis_acc | win;
         end
      end
   end

   assign hcount_out = pix_out.hcount;
   assign vcount_out = pix_out.vcount;
   assign hsync_out  = pix_out.hsync;
   assign vsync_out  = pix_out.vsync;
   assign hblnk_out  = pix_out.hblnk;
   assign vblnk_out  = pix_out.vblnk;
   assign rgb_out    = pix_out.rgb;

endmodule

// File: tb/tb_draw_circles_multi.sv
// -----------------------------------------------------------------------------
// tb_draw_circles_multi
// Drives pixels one per cycle; a reference model computes each pixel's
// expected output from plain circle geometry and pushes it, stamped with the
// cycle it must appear on, into a scoreboard queue. A monitor on the falling
// edge pops and compares.
// -----------------------------------------------------------------------------
module tb_draw_circles_multi;
   import vga_pkg::*;

   localparam int NUM_OBJ  = 4;
   localparam int RADIUS_W = 7;

   logic                        clk_in;
   logic                        rst;
   logic [HCOUNT_W-1:0]         hcount_in, vcount_in;
   logic                        hsync_in, vsync_in, hblnk_in, vblnk_in;
   logic [RGB_W-1:0]            rgb_in;
   logic [NUM_OBJ*HCOUNT_W-1:0] xpos_in, ypos_in;
   logic [NUM_OBJ*RADIUS_W-1:0] radius_in;
   logic [NUM_OBJ*RGB_W-1:0]    color_in;
   logic [NUM_OBJ-1:0]          obj_en_in;
   logic [HCOUNT_W-1:0]         hcount_out, vcount_out;
   logic                        hsync_out, vsync_out, hblnk_out, vblnk_out;
   logic [RGB_W-1:0]            rgb_out;
   logic [NUM_OBJ-1:0]          obj_visible;
   logic                        frame_done;

   draw_circles_multi #(
      .NUM_OBJ  (NUM_OBJ),
      .RADIUS_W (RADIUS_W)
   ) dut (
      .clk_in      (clk_in),
      .rst         (rst),
      .hcount_in   (hcount_in),
      .vcount_in   (vcount_in),
      .hsync_in    (hsync_in),
      .vsync_in    (vsync_in),
      .hblnk_in    (hblnk_in),
      .vblnk_in    (vblnk_in),
      .rgb_in      (rgb_in),
      .xpos_in     (xpos_in),
      .ypos_in     (ypos_in),
      .radius_in   (radius_in),
      .color_in    (color_in),
      .obj_en_in   (obj_en_in),
      .hcount_out  (hcount_out),
      .vcount_out  (vcount_out),
      .hsync_out   (hsync_out),
      .vsync_out   (vsync_out),
      .hblnk_out   (hblnk_out),
      .vblnk_out   (vblnk_out),
      .rgb_out     (rgb_out),
      .obj_visible (obj_visible),
      .frame_done  (frame_done)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   int tests  = 0;
   int failed = 0;
   int cyc    = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // --------------------------------------------------------------------------
   // Scoreboard
   // --------------------------------------------------------------------------
   typedef struct {
      int                 due;
      logic [RGB_W-1:0]   rgb;
      logic [27:0]        tim;
      logic               fd;
      logic [NUM_OBJ-1:0] vis;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   always @(negedge clk_in) begin
      if (rst) begin
         while (sb.size() > 0 && sb[0].due < cyc) begin
            check("sb_missed_slot", sb[0].due, cyc);
            void'(sb.pop_front());
         end
         if (sb.size() > 0 && sb[0].due == cyc) begin
            mon_e = sb.pop_front();
            check("rgb_out", rgb_out, mon_e.rgb);
            check("timing_out", {hcount_out, vcount_out, hsync_out, vsync_out,
                                 hblnk_out, vblnk_out}, mon_e.tim);
            check("frame_done", frame_done, mon_e.fd);
            check("obj_visible", obj_visible, mon_e.vis);
         end
      end
   end

   // --------------------------------------------------------------------------
   // Reference model: live object table (what the bench drives), the copy
   // taken at the last vblnk rise, and the visibility bookkeeping.
   // --------------------------------------------------------------------------
   int                 ob_x [NUM_OBJ], ob_y [NUM_OBJ], ob_r [NUM_OBJ];
   logic [RGB_W-1:0]   ob_c [NUM_OBJ];
   bit                 ob_en[NUM_OBJ];
   int                 sh_x [NUM_OBJ], sh_y [NUM_OBJ], sh_r [NUM_OBJ];
   logic [RGB_W-1:0]   sh_c [NUM_OBJ];
   bit                 sh_en[NUM_OBJ];
   bit                 m_prev_vb;
   logic [NUM_OBJ-1:0] m_acc, m_vis;

   task automatic set_obj(input int i, input int x, input int y, input int r,
                          input int c, input bit en);
      ob_x[i] = x; ob_y[i] = y; ob_r[i] = r; ob_c[i] = RGB_W'(c); ob_en[i] = en;
      xpos_in[i*HCOUNT_W +: HCOUNT_W]   = HCOUNT_W'(x);
      ypos_in[i*HCOUNT_W +: HCOUNT_W]   = HCOUNT_W'(y);
      radius_in[i*RADIUS_W +: RADIUS_W] = RADIUS_W'(r);
      color_in[i*RGB_W +: RGB_W]        = RGB_W'(c);
      obj_en_in[i]                      = en;
   endtask

   task automatic model_reset();
      for (int i = 0; i < NUM_OBJ; i++) begin
         sh_x[i] = 0; sh_y[i] = 0; sh_r[i] = 0; sh_c[i] = '0; sh_en[i] = 1'b0;
      end
      m_prev_vb = 1'b0;
      m_acc     = '0;
      m_vis     = '0;
   endtask

   // One pixel per call: drive it, work out what must come out 3 cycles later.
   task automatic drive_px(input int h, input int v, input bit hb, input bit vb);
      exp_t e;
      int   win;
      int   dx, dy;
      @(posedge clk_in);
      #1;
      hcount_in = HCOUNT_W'(h);
      vcount_in = HCOUNT_W'(v);
      hblnk_in  = hb;
      vblnk_in  = vb;
      hsync_in  = 1'($urandom_range(0, 1));
      vsync_in  = 1'($urandom_range(0, 1));
      rgb_in    = RGB_W'($urandom);
      win = -1;
      if (!hb && !vb) begin
         for (int i = 0; i < NUM_OBJ; i++) begin
            if (sh_en[i]) begin
               dx = h - sh_x[i];
               dy = v - sh_y[i];
               if (dx*dx + dy*dy <= sh_r[i]*sh_r[i]) begin
                  win = i;
                  break;
               end
            end
         end
      end
      e.due = cyc + 3;
      e.rgb = (win >= 0) ? sh_c[win] : rgb_in;
      e.tim = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};
      if (win >= 0) m_acc[win] = 1'b1;
      if (vb && !m_prev_vb) begin
         m_vis = m_acc;
         m_acc = '0;
         e.fd  = 1'b1;
         for (int i = 0; i < NUM_OBJ; i++) begin
            sh_x[i] = ob_x[i]; sh_y[i] = ob_y[i]; sh_r[i] = ob_r[i];
            sh_c[i] = ob_c[i]; sh_en[i] = ob_en[i];
         end
      end else begin
         e.fd = 1'b0;
      end
      m_prev_vb = vb;
      e.vis     = m_vis;
      sb.push_back(e);
   endtask

   task automatic blank(input int n);
      for (int k = 0; k < n; k++) drive_px(1024 + k, 800, 1'b1, 1'b1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rgb"}, rgb_out, 0);
      check({tag, "_timing"}, {hcount_out, vcount_out, hsync_out, vsync_out,
                               hblnk_out, vblnk_out}, 0);
      check({tag, "_frame_done"}, frame_done, 0);
      check({tag, "_obj_visible"}, obj_visible, 0);
   endtask

   function automatic int clamp12(input int v);
      if (v < 0)    return 0;
      if (v > 4095) return 4095;
      return v;
   endfunction

   // --------------------------------------------------------------------------
   // Stimulus
   // --------------------------------------------------------------------------
   initial begin
      int k, h, v, off;
      hcount_in = '0; vcount_in = '0; hsync_in = 0; vsync_in = 0;
      hblnk_in = 0; vblnk_in = 0; rgb_in = '0;
      xpos_in = '0; ypos_in = '0; radius_in = '0; color_in = '0; obj_en_in = '0;
      for (int i = 0; i < NUM_OBJ; i++) set_obj(i, 0, 0, 0, 0, 1'b0);
      model_reset();

      rst = 1'b1;
      #2 rst = 1'b0;
      #1 check_all_zero("reset");
      repeat (2) @(posedge clk_in);
      #1 rst = 1'b1;

      // Objects programmed but not yet latched: passthrough.
      set_obj(0, 100, 100, 20, 'hf00, 1'b1);
      drive_px(100, 100, 0, 0);
      drive_px(120, 100, 0, 0);
      drive_px(110, 105, 0, 0);
      blank(4);

      // Single object: edge of radius, just outside, diagonal inside.
      drive_px(120, 100, 0, 0);
      drive_px(121, 100, 0, 0);
      drive_px(114, 114, 0, 0);
      drive_px(115, 115, 0, 0);
      drive_px(100, 100, 0, 0);
      drive_px(80, 100, 0, 0);
      drive_px(79, 100, 0, 0);
      drive_px(100, 120, 1, 0);
      for (int n = 0; n < 40; n++)
         drive_px($urandom_range(75, 125), $urandom_range(75, 125), 0, 0);

      // Tear-free: move mid-frame, old position persists until vblnk.
      set_obj(0, 300, 100, 20, 'hf00, 1'b1);
      drive_px(100, 100, 0, 0);
      drive_px(300, 100, 0, 0);
      drive_px(110, 100, 0, 0);
      blank(4);
      drive_px(100, 100, 0, 0);
      drive_px(300, 100, 0, 0);
      drive_px(310, 100, 0, 0);

      // Priority between overlapping objects.
      set_obj(0, 200, 200, 20, 'hf00, 1'b1);
      set_obj(1, 205, 200, 20, 'h00b, 1'b1);
      blank(4);
      drive_px(205, 200, 0, 0);
      drive_px(222, 200, 0, 0);
      drive_px(220, 200, 0, 0);
      drive_px(225, 200, 0, 0);
      drive_px(226, 200, 0, 0);
      for (int x = 178; x <= 228; x++) drive_px(x, 203, 0, 0);

      // Edge and off-screen centres.
      set_obj(0, 0, 0, 0, 0, 1'b0);
      set_obj(1, 0, 0, 0, 0, 1'b0);
      set_obj(2, 0, 5, 10, 'h0f0, 1'b1);
      set_obj(3, 2000, 100, 50, 'hfff, 1'b1);
      blank(4);
      drive_px(0, 5, 0, 0);
      drive_px(10, 5, 0, 0);
      drive_px(11, 5, 0, 0);
      drive_px(1023, 5, 0, 0);
      drive_px(4095, 5, 0, 0);
      drive_px(0, 15, 0, 0);
      drive_px(0, 4095, 0, 0);
      for (int x = 0; x < 1024; x += 16) drive_px(x, 100, 0, 0);
      blank(4);

      // Visibility: obj3 sits entirely under obj0, obj1 disabled.
      set_obj(0, 300, 300, 40, 'hf00, 1'b1);
      set_obj(1, 500, 300, 10, 'h0f0, 1'b0);
      set_obj(2, 600, 400, 10, 'h00f, 1'b1);
      set_obj(3, 305, 300, 5, 'hfff, 1'b1);
      blank(4);
      for (int y = 295; y <= 305; y++)
         for (int x = 255; x <= 345; x++) drive_px(x, y, 0, 0);
      drive_px(600, 400, 0, 0);
      drive_px(500, 300, 0, 0);
      blank(4);

      // Randomised frames.
      for (int f = 0; f < 6; f++) begin
         for (int i = 0; i < NUM_OBJ; i++) begin
            h = ($urandom_range(0, 9) == 0) ? $urandom_range(1500, 4095) : $urandom_range(0, 1100);
            v = $urandom_range(0, 820);
            set_obj(i, h, v, $urandom_range(0, 127), $urandom, $urandom_range(0, 3) != 0);
         end
         blank(4);
         for (int n = 0; n < 400; n++) begin
            k = $urandom_range(0, NUM_OBJ - 1);
            if ($urandom_range(0, 9) < 6) begin
               off = ob_r[k] + 3;
               h = clamp12(ob_x[k] + $urandom_range(0, 2*off) - off);
               v = clamp12(ob_y[k] + $urandom_range(0, 2*off) - off);
            end else begin
               h = $urandom_range(0, 1343);
               v = $urandom_range(0, 805);
            end
            drive_px(h, v, $urandom_range(0, 29) == 0, 0);
         end
      end
      blank(4);

      // Reset in the middle of a frame with drawing active.
      set_obj(0, 300, 300, 40, 'hf00, 1'b1);
      blank(4);
      for (int x = 280; x < 300; x++) drive_px(x, 300, 0, 0);
      @(posedge clk_in);
      #1 rst = 1'b0;
      sb.delete();
      model_reset();
      #1 check_all_zero("mid_reset");
      repeat (3) @(posedge clk_in);
      #1 rst = 1'b1;
      // Shadows are cleared: passthrough, and no frame_done without a rise.
      for (int x = 280; x < 330; x++) drive_px(x, 300, 0, 0);
      blank(4);
      for (int x = 280; x < 300; x++) drive_px(x, 300, 0, 0);
      blank(4);

      for (int n = 0; n < 10 && sb.size() > 0; n++) @(negedge clk_in);
      #1 check("sb_drain", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
